// File: rtl/alu_pkg.sv
// Shared definitions for the alu4 datapath and the two-port alu4 arbiter.
//   alu_op_t  : 2-bit ALU operation code, every encoding defined
//   arb_state_t : arbiter control states
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    AND = 2'd2,
    OR  = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int DATA_W = 4;

endpackage

// File: rtl/alu4.sv
// 4-bit combinational ALU.
//   op  : operation (ADD/SUB/AND/OR)
//   A,B : operands; for subtraction the caller supplies ~B and Cin=1
//   Cin : carry in for the adder path
//   S   : 4-bit result
//   V   : adder carry-out for ADD/SUB, 0 for logic ops
module alu4
  import alu_pkg::*;
(
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Cin,
  output logic [DATA_W-1:0] S,
  output logic              V
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, A} + {1'b0, B} + {{DATA_W{1'b0}}, Cin};

  always_comb begin
    S = '0;
    V = 1'b0;
    case (op)
      ADD, SUB: begin
        S = sum[DATA_W-1:0];
        V = sum[DATA_W];
      end
      AND:     S = A & B;
      OR:      S = A | B;
      default: begin
        S = '0;
        V = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu4_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant.
//   v0, v1     : request valid bits
//   last_grant : port granted most recently (0 or 1)
//   grant      : one-hot grant, zero when nothing is requesting
module rr_arb2 (
  input  logic       v0,
  input  logic       v1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (v0 && v1) begin
      // Contention: favour the port that was not served last.
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (v0) begin
      grant = 2'b01;
    end else if (v1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/alu4_arbiter.sv
// Shares a single alu4 between two requesters, one transaction at a time.
//   clk, rst            : clock, asynchronous active-high reset
//   reqN_valid/ready    : request handshake for port N
//   reqN_A/B/op         : request operands, latched on acceptance
//   rspN_valid/ready    : response handshake for port N (only the owner sees valid)
//   rspN_S/V            : registered result and carry/overflow flag
// Flow: IDLE (arbitrate, accept) -> EXEC (compute) -> RESP (hold until taken).
module alu4_arbiter
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  alu_op_t           req0_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_S,
  output logic              rsp0_V,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  input  alu_op_t           req1_op,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_S,
  output logic              rsp1_V
);

  arb_state_t        state;
  logic              owner;
  logic              last_grant;
  logic [1:0]        grant;
  logic              rsp_take;

  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;
  alu_op_t           op_p0;

  logic [DATA_W-1:0] alu_b;
  logic              alu_cin;
  logic [DATA_W-1:0] alu_s;
  logic              alu_v;

  logic [DATA_W-1:0] s_p1;
  logic              v_p1;

  rr_arb2 u_arb (
    .v0         (req0_valid),
    .v1         (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;
  assign rsp0_S     = s_p1;
  assign rsp0_V     = v_p1;
  assign rsp1_S     = s_p1;
  assign rsp1_V     = v_p1;

  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;

  // Subtraction is A + ~B + 1 so the adder carry-out means "no borrow".
  assign alu_b   = (op_p0 == SUB) ? ~b_p0 : b_p0;
  assign alu_cin = (op_p0 == SUB);

  alu4 u_alu (
    .op  (op_p0),
    .A   (a_p0),
    .B   (alu_b),
    .Cin (alu_cin),
    .S   (alu_s),
    .V   (alu_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      a_p0       <= '0;
      b_p0       <= '0;
      op_p0      <= ADD;
      s_p1       <= '0;
      v_p1       <= 1'b0;
    end else begin
      case (state)
        // Stage p0: capture the granted port's operands.
        IDLE: begin
          if (grant != 2'b00) begin
            a_p0       <= grant[1] ? req1_A  : req0_A;
            b_p0       <= grant[1] ? req1_B  : req0_B;
            op_p0      <= grant[1] ? req1_op : req0_op;
            owner      <= grant[1];
            last_grant <= grant[1];
            state      <= EXEC;
          end
        end
        // Stage p1: register the ALU result.
        EXEC: begin
          s_p1  <= alu_s;
          v_p1  <= alu_v;
          state <= RESP;
        end
        RESP: begin
          if (rsp_take) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu4_arbiter.sv
module tb_alu4_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_A [2];
  logic [3:0] req_B [2];
  alu_op_t    req_op [2];
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [3:0] rsp_S [2];
  logic [1:0] rsp_V;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu4_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req_valid[0]),
    .req0_ready (req_ready[0]),
    .req0_A     (req_A[0]),
    .req0_B     (req_B[0]),
    .req0_op    (req_op[0]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_ready (rsp_ready[0]),
    .rsp0_S     (rsp_S[0]),
    .rsp0_V     (rsp_V[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req_ready[1]),
    .req1_A     (req_A[1]),
    .req1_B     (req_B[1]),
    .req1_op    (req_op[1]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_ready (rsp_ready[1]),
    .rsp1_S     (rsp_S[1]),
    .rsp1_V     (rsp_V[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp0_S"}, {28'd0, rsp_S[0]}, 32'd0);
    chk({tag, "_rsp1_S"}, {28'd0, rsp_S[1]}, 32'd0);
    chk({tag, "_rsp_V"}, {30'd0, rsp_V}, 32'd0);
  endtask

  task automatic set_req(input int p, input logic [3:0] a, input logic [3:0] b, input alu_op_t op);
    req_valid[p] = 1'b1;
    req_A[p]     = a;
    req_B[p]     = b;
    req_op[p]    = op;
  endtask

  // Single transaction on an idle block; entered and left at a falling edge.
  task automatic txn(input string tag, input int p, input logic [3:0] a, input logic [3:0] b,
                     input alu_op_t op, input logic [3:0] es, input logic ev);
    @(negedge clk);
    set_req(p, a, b, op);
    #1 chk({tag, "_ready"}, {31'd0, req_ready[p]}, 32'd1);
    @(negedge clk);
    req_valid[p] = 1'b0;
    #1 chk({tag, "_exec_valid"}, {30'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_valid"}, {31'd0, rsp_valid[p]}, 32'd1);
    chk({tag, "_other_valid"}, {31'd0, rsp_valid[1-p]}, 32'd0);
    chk({tag, "_S"}, {28'd0, rsp_S[p]}, {28'd0, es});
    chk({tag, "_V"}, {31'd0, rsp_V[p]}, {31'd0, ev});
    rsp_ready[p] = 1'b1;
    @(negedge clk);
    rsp_ready[p] = 1'b0;
    #1 chk({tag, "_done_valid"}, {30'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_s [2];
    logic       exp_v [2];
    int         p;

    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_A[i]  = 4'h0;
      req_B[i]  = 4'h0;
      req_op[i] = ADD;
    end
    #1 chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic single-port transactions.
    txn("p0_add", 0, 4'h7, 4'h9, ADD, 4'h0, 1'b1);
    txn("p1_sub_pos", 1, 4'h5, 4'h3, SUB, 4'h2, 1'b1);
    txn("p1_sub_neg", 1, 4'h3, 4'h5, SUB, 4'hE, 1'b0);
    txn("p1_and", 1, 4'hC, 4'hA, AND, 4'h8, 1'b0);
    txn("p1_or", 1, 4'hC, 4'hA, OR, 4'hE, 1'b0);
    txn("p0_add_small", 0, 4'h3, 4'h4, ADD, 4'h7, 1'b0);

    // Both ports continuously valid from reset: grants alternate 0,1,0,1.
    @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("rr_reset");
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 4'h1, 4'h2, ADD);
    set_req(1, 4'h2, 4'h3, SUB);
    rsp_ready = 2'b11;
    exp_s[0] = 4'h3; exp_v[0] = 1'b0;
    exp_s[1] = 4'hF; exp_v[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      p = (k / 3) % 2;
      #1;
      if (k % 3 == 0) begin
        chk($sformatf("rr%0d_ready_own", k), {31'd0, req_ready[p]}, 32'd1);
        chk($sformatf("rr%0d_ready_other", k), {31'd0, req_ready[1-p]}, 32'd0);
      end else if (k % 3 == 1) begin
        chk($sformatf("rr%0d_exec", k), {28'd0, req_ready, rsp_valid}, 32'd0);
      end else begin
        chk($sformatf("rr%0d_valid_own", k), {31'd0, rsp_valid[p]}, 32'd1);
        chk($sformatf("rr%0d_valid_other", k), {31'd0, rsp_valid[1-p]}, 32'd0);
        chk($sformatf("rr%0d_S", k), {28'd0, rsp_S[p]}, {28'd0, exp_s[p]});
        chk($sformatf("rr%0d_V", k), {31'd0, rsp_V[p]}, {31'd0, exp_v[p]});
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // Backpressure on port 0 while port 1 waits.
    set_req(0, 4'hF, 4'h3, AND);
    set_req(1, 4'h1, 4'h8, OR);
    #1;
    chk("bp_ready0", {31'd0, req_ready[0]}, 32'd1);
    chk("bp_ready1", {31'd0, req_ready[1]}, 32'd0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("bp%0d_valid", k), {30'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_S", k), {28'd0, rsp_S[0]}, 32'h3);
      chk($sformatf("bp%0d_V", k), {31'd0, rsp_V[0]}, 32'd0);
      chk($sformatf("bp%0d_ready1", k), {31'd0, req_ready[1]}, 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    #1;
    chk("bp_after_ready1", {31'd0, req_ready[1]}, 32'd1);
    chk("bp_after_valid0", {31'd0, rsp_valid[0]}, 32'd0);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    chk("bp_p1_valid", {30'd0, rsp_valid}, 32'd2);
    chk("bp_p1_S", {28'd0, rsp_S[1]}, 32'h9);
    chk("bp_p1_V", {31'd0, rsp_V[1]}, 32'd0);
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;

    // Reset during EXEC.
    set_req(0, 4'h3, 4'h4, ADD);
    #1 chk("rx_ready", {31'd0, req_ready[0]}, 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1 chk_zero("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("rst_exec_no_rsp", {30'd0, rsp_valid}, 32'd0);

    // Reset during RESP.
    set_req(0, 4'h6, 4'h6, ADD);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    #1 chk("rr_pre_valid", {31'd0, rsp_valid[0]}, 32'd1);
    rst = 1'b1;
    #1 chk_zero("rst_resp");
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 4'h2, 4'h2, ADD);
    set_req(1, 4'h7, 4'h1, SUB);
    #1;
    chk("post_rst_ready0", {31'd0, req_ready[0]}, 32'd1);
    chk("post_rst_ready1", {31'd0, req_ready[1]}, 32'd0);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("post_rst_valid", {30'd0, rsp_valid}, 32'd1);
    chk("post_rst_S", {28'd0, rsp_S[0]}, 32'h4);
    chk("post_rst_V", {31'd0, rsp_V[0]}, 32'd0);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;

    // Operands change right after acceptance.
    set_req(0, 4'h9, 4'h4, SUB);
    #1 chk("latch_ready", {31'd0, req_ready[0]}, 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    req_A[0]     = 4'h0;
    req_B[0]     = 4'hF;
    req_op[0]    = OR;
    @(negedge clk);
    #1;
    chk("latch_valid", {30'd0, rsp_valid}, 32'd1);
    chk("latch_S", {28'd0, rsp_S[0]}, 32'h5);
    chk("latch_V", {31'd0, rsp_V[0]}, 32'd1);
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
